// File: rtl/i2c_master.sv
// Single-byte I2C master: START, {addr,op}, ACK, one data byte (write or read), ACK/NACK, STOP.
// Bus outputs are registered from the current state/quarter, so they trail the phase counter by one clk.
module i2c_master #(
    parameter int SYS_FREQ = 4000000,
    parameter int I2C_FREQ = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       newd,
    input  logic       op,
    input  logic [6:0] addr,
    input  logic [7:0] din,
    output logic       scl,
    inout  wire        sda,
    output logic [7:0] dout,
    output logic       busy,
    output logic       ack_err,
    output logic       done
);
    localparam int unsigned Q  = SYS_FREQ / I2C_FREQ / 4;
    localparam int unsigned CW = (Q > 1) ? $clog2(Q) : 1;

    typedef enum logic [3:0] {
        IDLE, START, WR_ADDR, ACK1, WR_DATA, RD_DATA, ACK2, MNACK, STOP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      qtr;
    logic [2:0]      bit_idx;
    logic            op_r;
    logic [6:0]      addr_r;
    logic [7:0]      din_r;
    logic [7:0]      rx;
    logic            samp;
    logic            sda_low;
    logic            tick;
    logic            bit_end;
    logic            samp_pt;
    logic [7:0]      tx_byte;

    assign sda = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        tick    = (cnt == CW'(Q - 1));
        bit_end = tick && (qtr == 2'd3);
        samp_pt = tick && (qtr == 2'd2);
        tx_byte = (state == WR_ADDR) ? {addr_r, op_r} : din_r;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            qtr     <= '0;
            bit_idx <= '0;
            op_r    <= 1'b0;
            addr_r  <= '0;
            din_r   <= '0;
            rx      <= '0;
            samp    <= 1'b0;
            scl     <= 1'b1;
            sda_low <= 1'b0;
            dout    <= '0;
            busy    <= 1'b0;
            ack_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
                qtr <= '0;
            end else begin
                cnt <= tick ? '0 : cnt + CW'(1);
                if (tick)
                    qtr <= qtr + 2'd1;
            end

            if (samp_pt)
                samp <= sda;
            if (samp_pt && state == RD_DATA)
                rx <= {rx[6:0], sda};

            // SDA is only updated from quarter 1 onward; quarter 0 holds the previous level
            case (state)
                IDLE: begin
                    scl     <= 1'b1;
                    sda_low <= 1'b0;
                end
                START: begin
                    scl     <= 1'b1;
                    sda_low <= qtr[1];
                end
                STOP: begin
                    scl     <= (qtr != 2'd0);
                    sda_low <= ~qtr[1];
                end
                WR_ADDR, WR_DATA: begin
                    scl <= qtr[1];
                    if (qtr != 2'd0)
                        sda_low <= ~tx_byte[bit_idx];
                end
                default: begin
                    scl <= qtr[1];
                    if (qtr != 2'd0)
                        sda_low <= 1'b0;
                end
            endcase

            case (state)
                IDLE: begin
                    if (newd && !done) begin
                        op_r    <= op;
                        addr_r  <= addr;
                        din_r   <= din;
                        busy    <= 1'b1;
                        ack_err <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= 3'd7;
                        state   <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd0)
                            state <= ACK1;
                        else
                            bit_idx <= bit_idx - 3'd1;
                    end
                end
                ACK1: begin
                    if (bit_end) begin
                        bit_idx <= 3'd7;
                        if (samp) begin
                            ack_err <= 1'b1;
                            state   <= STOP;
                        end else begin
                            state <= op_r ? RD_DATA : WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd0)
                            state <= ACK2;
                        else
                            bit_idx <= bit_idx - 3'd1;
                    end
                end
                RD_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd0) begin
                            dout  <= rx;
                            state <= MNACK;
                        end else begin
                            bit_idx <= bit_idx - 3'd1;
                        end
                    end
                end
                ACK2: begin
                    if (bit_end) begin
                        if (samp)
                            ack_err <= 1'b1;
                        state <= STOP;
                    end
                end
                MNACK: begin
                    if (bit_end)
                        state <= STOP;
                end
                STOP: begin
                    if (bit_end) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter SYS_FREQ, default 4000000: system clock frequency in Hz.
REQ-002 Parameter I2C_FREQ, default 100000: SCL frequency in Hz.
REQ-003 Port clk, input, 1: single system clock, rising-edge active.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port newd, input, 1: transaction request, sampled in IDLE only.
REQ-006 Port op, input, 1: 1 = read, 0 = write; captured with newd.
REQ-007 Port addr, input, 7: target slave address, captured with newd.
REQ-008 Port din, input, 8: write data byte, captured with newd.
REQ-009 Port scl, output, 1: I2C clock, driven by the master.
REQ-010 Port sda, inout, 1: open-drain data line; drives 0 or Z only, never 1.
REQ-011 Port dout, output, 8: byte received on a read.
REQ-012 Port busy, output, 1: high from newd acceptance until done.
REQ-013 Port ack_err, output, 1: slave NACK flag for the last transaction.
REQ-014 Port done, output, 1: one-cycle end-of-transaction pulse.

Function
REQ-015 Each bit time SHALL be 4 quarters of Q = SYS_FREQ/I2C_FREQ/4 clk cycles; Q = 10 and bit = 40 cycles at defaults.
REQ-016 Quarter counter and phase SHALL run only while busy and SHALL be held at quarter 0, count 0 in IDLE.
REQ-017 Data, address and ACK bits: SCL low in quarters 0-1, high in quarters 2-3; SDA changes only at the start of quarter 1.
REQ-018 Received bits, including ACK, SHALL be sampled on the last clk of quarter 2 (SCL high).
REQ-019 Format SHALL be START, {addr, op} MSB first, slave ACK, data byte MSB first, ACK/NACK bit, STOP.
REQ-020 START bit: SCL high for all 4 quarters; SDA released in quarters 0-1, driven 0 in quarters 2-3.
REQ-021 STOP bit: SCL low in quarter 0, high in quarters 1-3; SDA driven 0 in quarters 0-1, released in quarters 2-3.
REQ-022 States: IDLE, START, WR_ADDR, ACK1, WR_DATA, RD_DATA, ACK2, MNACK, STOP.
REQ-023 IDLE -> START when newd=1, capturing op/addr/din and setting busy; ack_err cleared at the same edge.
REQ-024 START -> WR_ADDR -> ACK1 after 1 and 8 bit times; in ACK1, SDA is released.
REQ-025 ACK1 with sampled SDA=1: set ack_err, go to STOP, skip the data phase.
REQ-026 ACK1 with sampled SDA=0: go to WR_DATA if op=0, else RD_DATA.
REQ-027 WR_DATA -> ACK2 after 8 bits; ACK2 samples SDA, sets ack_err on 1, then goes to STOP.
REQ-028 RD_DATA: SDA released; shift 8 sampled bits MSB first; dout updated at the end of bit 8; then MNACK.
REQ-029 MNACK: master releases SDA (NACK) for one bit time, then goes to STOP.
REQ-030 STOP end: done=1 for exactly one clk, busy=0, return to IDLE.
REQ-031 Latency from newd to done SHALL be 20 bit times (800 clk) for a full read or write, and 11 bit times (440 clk) on address NACK.
REQ-032 newd while busy SHALL be ignored, with no effect on captured fields.
REQ-033 newd asserted on the same clk as done SHALL be ignored; it is accepted from the following cycle.
REQ-034 ack_err and dout SHALL hold their values until the next accepted newd; dout is not altered by writes.

Reset
REQ-035 rst=1 SHALL immediately and asynchronously force: state IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, dout=0x00, counters 0.
REQ-036 Reset mid-transaction SHALL abort with no STOP generated and no done pulse.

Verification
REQ-037 Write addr=0x50, din=0xA5, slave ACKs -> SDA bytes 0xA0 then 0xA5; done at +800 clk; ack_err=0.
REQ-038 Read addr=0x50, slave returns 0x3C -> byte 0xA1 sent, dout=0x3C, master NACK, STOP, ack_err=0.
REQ-039 No slave, SDA pulled high -> ack_err=1, STOP after the address, done at +440 clk.
REQ-040 Write where the slave NACKs data -> ack_err=1, done at +800 clk.
REQ-041 newd pulsed at +100 clk of an active transfer -> ignored; only one transaction is observed.
REQ-042 rst asserted during WR_DATA -> scl=1, sda=Z, busy=0 at once; a next newd runs a normal transaction.
